// File: rtl/register_file_if.sv
// Register file bus: write port from writeback plus two read ports to the ALU.
// The master drives addresses and write data; the slave (the register file) drives read data.
interface register_file_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
);
   logic                  write_enable;
   logic [ADDR_WIDTH-1:0] write_reg;
   logic [DATA_WIDTH-1:0] write_data;
   logic [ADDR_WIDTH-1:0] read_reg1;
   logic [ADDR_WIDTH-1:0] read_reg2;
   logic [DATA_WIDTH-1:0] read_data1;
   logic [DATA_WIDTH-1:0] read_data2;

   modport master (
      output write_enable, write_reg, write_data, read_reg1, read_reg2,
      input  read_data1, read_data2
   );

   modport slave (
      input  write_enable, write_reg, write_data, read_reg1, read_reg2,
      output read_data1, read_data2
   );
endinterface

// File: rtl/register_file.sv
// General-purpose register file: 2**ADDR_WIDTH entries, two combinational read ports,
// one synchronous write port, asynchronous active-low clear.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the
// read ports before the capturing edge.
module register_file #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   register_file_if.slave rf
);
   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [Depth];
   logic [DATA_WIDTH-1:0] regs_d [Depth];

   // Next state: only the addressed entry takes write data, and only when enabled, so
   // undriven address/data cannot disturb storage while writes are off.
   always_comb begin
      for (int unsigned i = 0; i < Depth; i++) begin
         regs_d[i] = regs_q[i];
         if (rf.write_enable == 1'b1 && rf.write_reg == ADDR_WIDTH'(i)) begin
            regs_d[i] = rf.write_data;
         end
      end
   end

   // Storage: asynchronous clear overrides any simultaneous write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < Depth; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Read port 1: stored contents, optionally overridden by an in-flight write.
   always_comb begin
      rf.read_data1 = regs_q[rf.read_reg1];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && rf.write_enable == 1'b1 && rf.read_reg1 == rf.write_reg) begin
         rf.read_data1 = rf.write_data;
      end
`endif
   end

   // Read port 2: same behaviour as port 1.
   always_comb begin
      rf.read_data2 = regs_q[rf.read_reg2];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && rf.write_enable == 1'b1 && rf.read_reg2 == rf.write_reg) begin
         rf.read_data2 = rf.write_data;
      end
`endif
   end
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed test-plan steps followed by random
// traffic, all compared against an array model of the eight registers.
module tb_register_file;
   logic clk;
   logic rst_n;

   register_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) rf_if ();

   register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (rf_if.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] model [8];
`ifdef REGFILE_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected read value from the model given the currently driven inputs.
   function automatic logic [7:0] exp_read(input logic [2:0] addr);
      if (Bypass && rst_n === 1'b1 && rf_if.write_enable === 1'b1 &&
          addr === rf_if.write_reg) begin
         return rf_if.write_data;
      end
      return model[addr];
   endfunction

   task automatic check_ports(input string tag);
      check({tag, "_rd1"}, rf_if.read_data1, exp_read(rf_if.read_reg1));
      check({tag, "_rd2"}, rf_if.read_data2, exp_read(rf_if.read_reg2));
   endtask

   // One clock: drive after the falling edge, check before and after the rising edge.
   task automatic cycle(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic [2:0] ra1, input logic [2:0] ra2, input string tag);
      @(negedge clk);
      rf_if.write_enable = we;
      rf_if.write_reg    = wa;
      rf_if.write_data   = wd;
      rf_if.read_reg1    = ra1;
      rf_if.read_reg2    = ra2;
      #1;
      check_ports({tag, "_pre"});
      @(posedge clk);
      if (rst_n === 1'b1 && we === 1'b1) model[wa] = wd;
      #1;
      check_ports({tag, "_post"});
   endtask

   task automatic set_reads(input logic [2:0] ra1, input logic [2:0] ra2);
      rf_if.read_reg1 = ra1;
      rf_if.read_reg2 = ra2;
      #1;
   endtask

   initial begin
      logic [2:0] a;
      logic [2:0] b;
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      rst_n              = 1'b0;
      rf_if.write_enable = 1'b0;
      rf_if.write_reg    = 3'd0;
      rf_if.write_data   = 8'h00;
      rf_if.read_reg1    = 3'd5;
      rf_if.read_reg2    = 3'd7;
      #3;
      check("reset_state_rd1", rf_if.read_data1, 8'h00);
      check("reset_state_rd2", rf_if.read_data2, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic writes
      cycle(1'b1, 3'd0, 8'd13, 3'd0, 3'd1, "wr_r0");
      cycle(1'b1, 3'd1, 8'd25, 3'd0, 3'd1, "wr_r1");
      cycle(1'b0, 3'd0, 8'd0, 3'd0, 3'd1, "basic_rd");
      check("basic_r0", rf_if.read_data1, 8'd13);
      check("basic_r1", rf_if.read_data2, 8'd25);

      // Write disabled, including undriven address/data
      for (int i = 0; i < 3; i++) cycle(1'b0, 3'd2, 8'd99, 3'd2, 3'd2, "wdis");
      cycle(1'b0, 3'bxxx, 8'hxx, 3'd2, 3'd0, "wdis_x");
      check("wdis_r2", rf_if.read_data1, 8'd0);
      check("wdis_r0", rf_if.read_data2, 8'd13);

      // All registers, then sweep both ports
      for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 8'(i * 17), 3'(i), 3'(7 - i), "wall");
      @(negedge clk);
      rf_if.write_enable = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_reads(3'(i), 3'(i));
         check("sweep_rd1", rf_if.read_data1, 8'(i * 17));
         check("sweep_same", rf_if.read_data2, rf_if.read_data1);
         set_reads(3'(i), 3'(7 - i));
         check("sweep_rd2", rf_if.read_data2, 8'((7 - i) * 17));
      end

      // Same-cycle read/write of r4
      cycle(1'b1, 3'd4, 8'd5, 3'd4, 3'd4, "r4_old");
      @(negedge clk);
      rf_if.write_enable = 1'b1;
      rf_if.write_reg    = 3'd4;
      rf_if.write_data   = 8'd77;
      rf_if.read_reg1    = 3'd4;
      rf_if.read_reg2    = 3'd3;
      #1;
      check("r4_before_edge", rf_if.read_data1, Bypass ? 8'd77 : 8'd5);
      check("r4_other_port", rf_if.read_data2, 8'd51);
      @(posedge clk);
      model[4] = 8'd77;
      #1;
      check("r4_after_edge", rf_if.read_data1, 8'd77);

      // Overwrite, back-to-back on the same register
      cycle(1'b1, 3'd6, 8'd10, 3'd6, 3'd5, "ow1");
      cycle(1'b1, 3'd6, 8'd200, 3'd6, 3'd5, "ow2");
      cycle(1'b0, 3'd6, 8'd1, 3'd6, 3'd6, "ow_rd");
      check("overwrite_r6", rf_if.read_data1, 8'd200);

      // Random traffic against the model
      for (int n = 0; n < 200; n++) begin
         a = 3'($urandom_range(7));
         b = 3'($urandom_range(7));
         cycle(1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom),
               ($urandom_range(3) == 0) ? rf_if.write_reg : a, b, "rand");
      end

      // Asynchronous reset mid-cycle after writing FF to r3
      cycle(1'b1, 3'd3, 8'hFF, 3'd3, 3'd3, "r3_ff");
      check("r3_ff_val", rf_if.read_data1, 8'hFF);
      @(negedge clk);
      rf_if.write_enable = 1'b0;
      rf_if.read_reg1    = 3'd3;
      rf_if.read_reg2    = 3'd6;
      #2;
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      #1;
      check("async_rst_rd1", rf_if.read_data1, 8'h00);
      check("async_rst_rd2", rf_if.read_data2, 8'h00);
      // Reset overrides a write presented across an edge
      rf_if.write_enable = 1'b1;
      rf_if.write_reg    = 3'd3;
      rf_if.write_data   = 8'hAA;
      #1;
      check("rst_no_bypass", rf_if.read_data1, 8'h00);
      @(posedge clk);
      #1;
      check("rst_over_write", rf_if.read_data1, 8'h00);
      @(negedge clk);
      rf_if.write_enable = 1'b0;
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         set_reads(3'(i), 3'(7 - i));
         check("post_rst_rd1", rf_if.read_data1, 8'h00);
      end
      cycle(1'b1, 3'd3, 8'h3C, 3'd3, 3'd0, "after_rst_wr");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time limit in case the clock or a wait misbehaves.
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
